// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared state encoding and sizing helpers for the sweeper
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int n_vec(input int n_in);
    return 1 << n_in;
  endfunction

  // Never narrower than one bit, even for degenerate SETTLE values.
  function automatic int cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - vector/response bundle between the sweeper and the two implementations
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic                 s_ref;
  logic                 s_opt;
  logic [N_IN-1:0]      vec_out;
  logic                 busy;
  logic                 done;
  logic [(1<<N_IN)-1:0] table_ref;
  logic [(1<<N_IN)-1:0] mismatch_mask;
  logic                 equivalent;
  logic [N_IN-1:0]      first_mismatch;
  logic [N_IN:0]        mismatch_count;

  modport master (
    input  start, s_ref, s_opt,
    output vec_out, busy, done, table_ref, mismatch_mask,
           equivalent, first_mismatch, mismatch_count
  );

  modport slave (
    output start, s_ref, s_opt,
    input  vec_out, busy, done, table_ref, mismatch_mask,
           equivalent, first_mismatch, mismatch_count
  );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// rtl/truth_table_sweeper_settle_timer.sv - per-vector settle counter: load to 0, count up, flag SETTLE-1
module settle_timer #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = (cnt_q == CNT_W'(SETTLE - 1));

  // Counting saturates at the expire value so a stalled count_i cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - clocked exhaustive equivalence sweep of a reference vs minimized function
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  truth_table_sweeper_if.master bus
);

  localparam int N_VEC = n_vec(N_IN);
  localparam int CNT_W = cnt_w(SETTLE);

  if (SETTLE < 1) begin : g_settle_check
    $error("truth_table_sweeper: SETTLE must be >= 1");
  end

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_VEC-1:0]  table_q, table_d;
  logic [N_VEC-1:0]  mask_q, mask_d;
  logic [N_IN:0]     count_q, count_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic              equiv_q, equiv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_load;
  logic              timer_count;
  logic              timer_expired;
  logic              miss;

  settle_timer #(
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) u_settle_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (timer_load),
    .count_i   (timer_count),
    .expired_o (timer_expired)
  );

  assign miss = bus.s_ref ^ bus.s_opt;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    table_d     = table_q;
    mask_d      = mask_q;
    count_d     = count_q;
    first_d     = first_q;
    equiv_d     = equiv_q;
    timer_load  = 1'b0;
    timer_count = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          table_d    = '0;
          mask_d     = '0;
          count_d    = '0;
          first_d    = '0;
          equiv_d    = 1'b0;
          vec_d      = '0;
          timer_load = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (timer_expired) begin
          state_d = SAMPLE;
        end else begin
          timer_count = 1'b1;
        end
      end
      SAMPLE: begin
        table_d[vec_q] = bus.s_ref;
        mask_d[vec_q]  = miss;
        count_d        = count_q + {{N_IN{1'b0}}, miss};
        // A zero running count means no earlier vector of this sweep mismatched.
        if (miss && (count_q == '0)) begin
          first_d = vec_q;
        end
        if (vec_q == N_IN'(N_VEC - 1)) begin
          equiv_d = (mask_d == '0);
          state_d = DONE;
        end else begin
          vec_d      = vec_q + N_IN'(1);
          timer_load = 1'b1;
          state_d    = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      table_q <= '0;
      mask_q  <= '0;
      count_q <= '0;
      first_q <= '0;
      equiv_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      first_q <= first_d;
      equiv_q <= equiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.table_ref      = table_q;
  assign bus.mismatch_mask  = mask_q;
  assign bus.equivalent     = equiv_q;
  assign bus.first_mismatch = first_q;
  assign bus.mismatch_count = count_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench sweeping the minterm-1,2,3,5 function
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) if1 ();
  truth_table_sweeper_if #(.N_IN(3)) if3 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  int opt_mode = 0;

  function automatic logic f_ref(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return (~a & ~b & c) | (~a & b & ~c) | (~a & b & c) | (a & ~b & c);
  endfunction

  function automatic logic f_min(input logic [2:0] v);
    return (~v[1] & v[0]) | (~v[2] & v[1]);
  endfunction

  assign if1.s_ref = f_ref(if1.vec_out);
  assign if1.s_opt = (opt_mode == 1) ? (~if1.vec_out[2] & if1.vec_out[0]) :
                     (opt_mode == 2) ? ~f_ref(if1.vec_out) : f_min(if1.vec_out);
  assign if3.s_ref = f_ref(if3.vec_out);
  assign if3.s_opt = f_min(if3.vec_out);

  typedef struct {
    logic [7:0] tbl;
    logic [7:0] mask;
    logic       eq;
    logic [2:0] first;
    logic [3:0] cnt;
    int         done_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops one expectation per done pulse and tracks dut3 vector hold times.
  logic [2:0] prev3;
  int         run3 = 0;
  bit         trk3 = 0;

  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (if1.done) begin
      if (q1.size() == 0) begin
        fail_now("dut1_unexpected_done");
      end else begin
        e = q1.pop_front();
        chk("dut1_done_cycle", ncyc, e.done_cyc);
        chk("dut1_table_ref", if1.table_ref, e.tbl);
        chk("dut1_mask", if1.mismatch_mask, e.mask);
        chk("dut1_equivalent", if1.equivalent, e.eq);
        chk("dut1_first_mismatch", if1.first_mismatch, e.first);
        chk("dut1_count", if1.mismatch_count, e.cnt);
        chk("dut1_busy_in_done", if1.busy, 1);
      end
    end
    if (if3.busy) begin
      if (!trk3) begin
        trk3  = 1;
        prev3 = if3.vec_out;
        run3  = 1;
        chk("dut3_first_vec", if3.vec_out, 0);
      end else if (if3.vec_out != prev3) begin
        chk("dut3_hold_len", run3, 4);
        chk("dut3_step", if3.vec_out, 3'(prev3 + 3'd1));
        prev3 = if3.vec_out;
        run3  = 1;
      end else begin
        run3++;
      end
    end else begin
      trk3 = 0;
    end
    if (if3.done) begin
      chk("dut3_last_vec", if3.vec_out, 7);
      chk("dut3_last_run", run3, 5);
      if (q3.size() == 0) begin
        fail_now("dut3_unexpected_done");
      end else begin
        e = q3.pop_front();
        chk("dut3_done_cycle", ncyc, e.done_cyc);
        chk("dut3_table_ref", if3.table_ref, e.tbl);
        chk("dut3_mask", if3.mismatch_mask, e.mask);
        chk("dut3_equivalent", if3.equivalent, e.eq);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] tbl, input logic [7:0] mask, input logic eq,
                              input logic [2:0] first, input logic [3:0] cnt, input int dc);
    exp_t e;
    e.tbl = tbl; e.mask = mask; e.eq = eq; e.first = first; e.cnt = cnt; e.done_cyc = dc;
    return e;
  endfunction

  task automatic wait_idle1(input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (!if1.busy && !if1.done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic check_zero1(input string tag);
    chk({tag, "_vec"}, if1.vec_out, 0);
    chk({tag, "_busy"}, if1.busy, 0);
    chk({tag, "_done"}, if1.done, 0);
    chk({tag, "_table"}, if1.table_ref, 0);
    chk({tag, "_mask"}, if1.mismatch_mask, 0);
    chk({tag, "_equiv"}, if1.equivalent, 0);
    chk({tag, "_first"}, if1.first_mismatch, 0);
    chk({tag, "_count"}, if1.mismatch_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  base;
    bit  seen4;
    reset     = 1'b1;
    if1.start = 1'b0;
    if3.start = 1'b0;
    tick(2);
    check_zero1("reset");
    reset = 1'b0;
    tick(1);

    // Test 1: equivalent implementations, done at cycle 17.
    opt_mode = 0;
    base = ncyc;
    q1.push_back(mk(8'h2E, 8'h00, 1'b1, 3'd0, 4'd0, base + 18));
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    chk("t1_busy_after_accept", if1.busy, 1);
    wait_idle1(40, "t1_timeout");

    // Test 2: minimized side only covers minterms 1 and 3.
    opt_mode = 1;
    base = ncyc;
    q1.push_back(mk(8'h2E, 8'h24, 1'b0, 3'd2, 4'd2, base + 18));
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    wait_idle1(40, "t2_timeout");

    // Test 6: inverted minimized output mismatches everywhere.
    opt_mode = 2;
    base = ncyc;
    q1.push_back(mk(8'h2E, 8'hFF, 1'b0, 3'd0, 4'd8, base + 18));
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    wait_idle1(40, "t6_timeout");
    chk("t6_results_hold", if1.mismatch_mask, 8'hFF);
    chk("t6_vec_holds_last", if1.vec_out, 7);

    // Test 3: SETTLE=3, done at cycle 33.
    base = ncyc;
    q3.push_back(mk(8'h2E, 8'h00, 1'b1, 3'd0, 4'd0, base + 34));
    if3.start = 1'b1; tick(1); if3.start = 1'b0;
    begin
      bit ok3 = 0;
      for (int i = 0; i < 80; i++) begin
        tick(1);
        if (!if3.busy && !if3.done) begin
          ok3 = 1;
          break;
        end
      end
      if (!ok3) fail_now("t3_timeout");
    end

    // Test 4: asynchronous reset mid-sweep, then a clean sweep.
    opt_mode = 0;
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    seen4 = 0;
    for (int i = 0; i < 30; i++) begin
      if (if1.vec_out == 3'd4) begin
        seen4 = 1;
        break;
      end
      tick(1);
    end
    if (!seen4) fail_now("t4_vec4_timeout");
    #2 reset = 1'b1;
    #1 check_zero1("t4_async");
    tick(1);
    reset = 1'b0;
    tick(1);
    base = ncyc;
    q1.push_back(mk(8'h2E, 8'h00, 1'b1, 3'd0, 4'd0, base + 18));
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    wait_idle1(40, "t4_timeout");

    // Test 5: starts during the sweep are dropped; held start chains a second sweep.
    base = ncyc;
    q1.push_back(mk(8'h2E, 8'h00, 1'b1, 3'd0, 4'd0, base + 18));
    q1.push_back(mk(8'h2E, 8'h00, 1'b1, 3'd0, 4'd0, base + 36));
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    tick(4);
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    tick(3);
    if1.start = 1'b1; tick(1); if1.start = 1'b0;
    tick(2);
    if1.start = 1'b1;
    tick(6);
    chk("t5_idle_after_done", if1.busy, 0);
    tick(1);
    chk("t5_second_sweep_busy", if1.busy, 1);
    chk("t5_second_sweep_vec", if1.vec_out, 0);
    if1.start = 1'b0;
    wait_idle1(60, "t5_timeout");

    tick(3);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
